// File: rtl/sar_adc_seq.sv
// sar_adc_seq: SAR ADC controller with round-robin channel scan, averaging and offset calibration
module sar_adc_seq #(
    parameter int RES = 10,
    parameter int NCH = 4,
    parameter int SAMPLE_CYC = 2,
    parameter int AVG_MAX_LOG2 = 3,
    localparam int AW = (AVG_MAX_LOG2 > 0) ? $clog2(AVG_MAX_LOG2 + 1) : 1,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic           cal,
    input  logic [NCH-1:0] ch_mask,
    input  logic [AW-1:0]  avg_log2,
    input  logic           cmp,
    output logic           sample,
    output logic           cal_mode,
    output logic [RES-1:0] dac_code,
    output logic [CW-1:0]  ch_sel,
    output logic           busy,
    output logic           valid,
    output logic [RES-1:0] result,
    output logic [CW-1:0]  result_ch,
    output logic [RES-1:0] offset
);
    localparam int TW = $clog2((SAMPLE_CYC > RES) ? SAMPLE_CYC : RES);
    localparam int ACW = RES + AVG_MAX_LOG2;
    localparam int NW = AVG_MAX_LOG2 + 1;
    localparam logic [RES-1:0] MID = {1'b1, {(RES-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, SAMPLE, CONV, ACC, OUT} state_t;

    state_t         state, state_nx;
    logic [TW-1:0]  cyc;
    logic [RES-1:0] code, trial, avg, corr;
    logic [ACW-1:0] acc;
    logic [NW-1:0]  cnt;
    logic [AW-1:0]  avg_l, avg_clamp;
    logic [CW-1:0]  ptr, base, pick, idx, ch_inc;
    logic           cal_q, cal_pend, cal_req, start, start_cal, begin_res, last_conv;

    assign cal_req   = cal_pend | (cal & ~cal_q);
    assign start_cal = en & cal_req;
    assign start     = start_cal | (en & |ch_mask);
    assign begin_res = start & (state == IDLE || state == OUT);
    assign ch_inc    = (ch_sel == CW'(NCH - 1)) ? '0 : ch_sel + CW'(1);
    // After a normal result the search starts just past the channel that finished
    assign base      = (state == OUT && !cal_mode) ? ch_inc : ptr;
    assign trial     = code | (MID >> cyc);
    assign avg_clamp = (avg_log2 > AW'(AVG_MAX_LOG2)) ? AW'(AVG_MAX_LOG2) : avg_log2;
    assign avg       = RES'(acc >> avg_l);
    assign corr      = (avg >= offset) ? avg - offset : '0;
    assign last_conv = cnt == NW'((1 << avg_l) - 1);
    assign busy      = state != IDLE;

    // Pick the lowest enabled channel at or above base, wrapping round
    always_comb begin
        pick = '0;
        idx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = CW'((int'(base) + i) % NCH);
            if (ch_mask[idx]) pick = idx;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    end

    // Next state plus the analog-facing sample switch and DAC trial code
    always_comb begin
        state_nx = state;
        sample = 1'b0;
        dac_code = '0;
        case (state)
            IDLE: state_nx = start ? SAMPLE : IDLE;
            SAMPLE: begin
                sample = 1'b1;
                dac_code = MID;
                if (cyc == TW'(SAMPLE_CYC - 1)) state_nx = CONV;
            end
            CONV: begin
                dac_code = trial;
                if (cyc == TW'(RES - 1)) state_nx = ACC;
            end
            ACC: state_nx = last_conv ? OUT : SAMPLE;
            OUT: state_nx = start ? SAMPLE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: bit search, accumulation, result/offset and channel bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cyc <= '0;
            code <= '0;
            acc <= '0;
            cnt <= '0;
            avg_l <= '0;
            ptr <= '0;
            cal_q <= 1'b0;
            cal_pend <= 1'b0;
            cal_mode <= 1'b0;
            ch_sel <= '0;
            valid <= 1'b0;
            result <= '0;
            result_ch <= '0;
            offset <= '0;
        end else begin
            cal_q <= cal;
            cal_pend <= cal_req & ~(begin_res & start_cal);
            cyc <= (state_nx == state && (state == SAMPLE || state == CONV)) ? cyc + TW'(1) : '0;
            valid <= 1'b0;
            if (state == SAMPLE) code <= '0;
            if (state == CONV && cmp) code <= trial;
            if (state == ACC) begin
                acc <= acc + ACW'(code);
                cnt <= cnt + NW'(1);
            end
            if (state == OUT) begin
                acc <= '0;
                cal_mode <= 1'b0;
                if (cal_mode) offset <= avg;
                else begin
                    valid <= 1'b1;
                    result <= corr;
                    result_ch <= ch_sel;
                    ptr <= ch_inc;
                end
            end
            if (begin_res) begin
                cal_mode <= start_cal;
                avg_l <= avg_clamp;
                cnt <= '0;
                if (!start_cal) ch_sel <= pick;
            end
        end
    end
endmodule

// File: tb/tb_sar_adc_seq.sv
// tb_sar_adc_seq: self-checking bench for the SAR ADC sequencer with an ideal comparator model
module tb_sar_adc_seq;
    localparam int RES = 10;
    localparam int NCH = 4;
    localparam int SAMPLE_CYC = 2;
    localparam int AVG_MAX_LOG2 = 3;

    typedef struct { int ch; int val; } exp_t;

    logic clk = 1'b0, rstn = 1'b0, en = 1'b0, cal = 1'b0, cmp;
    logic [NCH-1:0] ch_mask = '0;
    logic [1:0] avg_log2 = '0;
    logic sample, cal_mode, busy, valid;
    logic [RES-1:0] dac_code, result, offset;
    logic [1:0] ch_sel, result_ch;

    int total = 0, bad = 0;
    int v_ch[NCH];
    int v_cal = 0, vin = 0, off_model = 0, cal_starts = 0;
    int seq_q[$];
    exp_t exp_q[$];
    exp_t e;
    int trace[RES];
    int lit[RES] = '{512, 768, 640, 576, 608, 624, 616, 612, 614, 613};
    int sp = 0, cp = 0, vp = 0, inconv = 0, k = 0, sc = 0;

    sar_adc_seq #(.RES(RES), .NCH(NCH), .SAMPLE_CYC(SAMPLE_CYC), .AVG_MAX_LOG2(AVG_MAX_LOG2)) dut (
        .clk(clk), .rstn(rstn), .en(en), .cal(cal), .ch_mask(ch_mask), .avg_log2(avg_log2),
        .cmp(cmp), .sample(sample), .cal_mode(cal_mode), .dac_code(dac_code), .ch_sel(ch_sel),
        .busy(busy), .valid(valid), .result(result), .result_ch(result_ch), .offset(offset)
    );

    always #5 clk = ~clk;

    // Ideal comparator: analog input vs DAC voltage
    assign cmp = vin >= int'(dac_code);

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Binary search on an ideal input: bits above b equal the input, bit b is the trial bit
    function automatic int trial_of(int v, int kk);
        int b = RES - 1 - kk;
        return ((v >> (b + 1)) << (b + 1)) | (1 << b);
    endfunction

    function automatic int model(int sum, int lg, int off);
        int a = sum >> lg;
        return (a > off) ? a - off : 0;
    endfunction

    // Per-cycle checker: sample phase, trial codes, calibration starts, result scoreboard
    always @(negedge clk) begin
        if (!rstn) begin
            sp = 0;
            cp = 0;
            vp = 0;
            inconv = 0;
        end else begin
            if (sample && sp == 0) begin
                if (cal_mode) vin = v_cal;
                else if (seq_q.size() > 0) vin = seq_q.pop_front();
                else vin = v_ch[ch_sel];
                sc = 0;
            end
            if (sample) begin
                sc++;
                chk("midscale", int'(dac_code), 1 << (RES - 1));
                inconv = 1;
                k = 0;
            end else if (inconv != 0) begin
                if (sp != 0) chk("sample_len", sc, SAMPLE_CYC);
                chk("trial", int'(dac_code), trial_of(vin, k));
                trace[k] = int'(dac_code);
                k++;
                if (k == RES) inconv = 0;
            end
            if (cal_mode && cp == 0) cal_starts++;
            if (valid) begin
                chk("valid_pulse", vp, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: result %0d ch %0d, none expected", result, result_ch);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", int'(result), e.val);
                    chk("result_ch", int'(result_ch), e.ch);
                end
            end
            sp = int'(sample);
            cp = int'(cal_mode);
            vp = int'(valid);
        end
    end

    task automatic wait_valid(input string nm, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!valid && n < 300);
        if (!valid) begin
            total++;
            bad++;
            $display("FAIL %s: no valid within %0d cycles", nm, n);
        end
    endtask

    task automatic one_result(input string nm, input int ch, input int val, input int lat);
        int n;
        exp_q.push_back('{ch, val});
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_valid(nm, n);
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int n, c0;
        v_ch = '{0, 0, 0, 0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", int'(sample), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_dac", int'(dac_code), 0);
        chk("rst_offset", int'(offset), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_cal_mode", int'(cal_mode), 0);
        rstn = 1'b1;
        ch_mask = 4'b0001;
        v_ch[0] = 612;
        one_result("conv612", 0, model(612, 0, off_model), 14);
        chk("conv612_lit", int'(result), 612);
        for (int i = 0; i < RES; i++) chk("trace612", trace[i], lit[i]);
        v_ch[0] = 1023;
        one_result("conv1023", 0, model(1023, 0, off_model), 14);
        chk("conv1023_lit", int'(result), 1023);
        v_ch[0] = 0;
        one_result("conv0", 0, model(0, 0, off_model), 14);
        chk("conv0_lit", int'(result), 0);
        avg_log2 = 2'd2;
        for (int i = 0; i < 4; i++) seq_q.push_back(100 + i);
        one_result("avg4", 0, model(406, 2, off_model), 53);
        chk("avg4_lit", int'(result), 101);
        avg_log2 = 2'd0;
        v_cal = 5;
        v_ch[0] = 3;
        off_model = v_cal;
        c0 = cal_starts;
        exp_q.push_back('{0, model(3, 0, off_model)});
        exp_q.push_back('{0, model(3, 0, off_model)});
        en = 1'b1;
        cal = 1'b1;
        @(posedge clk);
        #1;
        cal = 1'b0;
        chk("cal_mode_on", int'(cal_mode), 1);
        wait_valid("cal_then_ch", n);
        chk("cal_then_ch_latency", n, 28);
        en = 1'b0;
        wait_valid("ch_after_cal", n);
        chk("ch_after_cal_latency", n, 14);
        chk("cal_idle", int'(busy), 0);
        chk("offset_lit", int'(offset), 5);
        chk("sat_lit", int'(result), 0);
        chk("cal_count", cal_starts - c0, 1);
        v_ch[0] = 612;
        one_result("cal612", 0, model(612, 0, off_model), 14);
        chk("cal612_lit", int'(result), 607);
        v_ch = '{10, 20, 30, 40};
        ch_mask = 4'b1010;
        c0 = cal_starts;
        exp_q.push_back('{1, model(20, 0, off_model)});
        exp_q.push_back('{3, model(40, 0, off_model)});
        exp_q.push_back('{1, model(20, 0, off_model)});
        exp_q.push_back('{3, model(40, 0, off_model)});
        exp_q.push_back('{2, model(30, 0, off_model)});
        en = 1'b1;
        wait_valid("scan_a", n);
        for (int i = 0; i < 2; i++) begin
            cal = 1'b1;
            @(posedge clk);
            #1;
            cal = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_valid("scan_b", n);
        wait_valid("scan_c", n);
        chk("scan_cal_gap", n, 28);
        ch_mask = 4'b0100;
        wait_valid("scan_d", n);
        en = 1'b0;
        wait_valid("scan_e", n);
        chk("scan_ch2_lit", int'(result_ch), 2);
        chk("scan_idle", int'(busy), 0);
        chk("scan_cal_count", cal_starts - c0, 1);
        chk("scan_offset", int'(offset), 5);
        ch_mask = 4'b0000;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("mask0_busy", int'(busy), 0);
        end
        en = 1'b0;
        ch_mask = 4'b0001;
        v_ch[0] = 612;
        en = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_dac", int'(dac_code), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_offset", int'(offset), 0);
        off_model = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.push_back('{0, model(612, 0, off_model)});
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("restart_sample", int'(sample), 1);
        wait_valid("restart", n);
        chk("restart_latency", n, 14);
        chk("restart_idle", int'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
